posit_div_sched: RTL
====================

# posit_div_sched

Multi-cycle scheduler that shares one iterative posit divider datapath (operand decode, radix-2 mantissa divider, rounding stage) between `NREQ` requesters. It arbitrates requests round-robin and registers the winning operands. It then sequences the datapath through load, mantissa iteration and rounding-capture phases, and returns the rounded posit to the originating requester over a valid/ready response channel. It sits between the PPU issue logic and the divider datapath; the rounding stage itself stays combinational and is only sampled by this block.

## Interface
Parameters:
- `N`, 32, posit width
- `ES`, 2, exponent field width (passed through to the datapath, not used internally)
- `NREQ`, 2, number of requesters (≥2)
- `ITERS`, 2*N, mantissa quotient iterations, one quotient bit per `dp_step`
- `IDW`, $clog2(NREQ), requester id width

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in NREQ: request present, one bit per requester
- `req_in1`, `req_in2` in NREQ*N: packed dividend/divisor posits, requester i at bits [i*N +: N]
- `req_ready` out NREQ: one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `dp_in1`, `dp_in2` out N: registered operands to the datapath
- `dp_load` out 1: one-cycle pulse, datapath initialises its remainder and quotient
- `dp_step` out 1: high for exactly `ITERS` consecutive cycles
- `dp_special` in 1: zero/NaR operand flag from datapath decode, valid during `dp_load`
- `dp_out` in N: rounded posit from the rounding stage
- `resp_valid` out 1, `resp_ready` in 1: response handshake
- `resp_data` out N: result posit
- `resp_id` out IDW: index of the originating requester
- `busy` out 1: high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, ITER, ROUND, RESP.
- **IDLE:** `req_ready` = one-hot grant from the round-robin arbiter, combinational from `req_valid` and pointer `rr_ptr`. The search starts at `rr_ptr` and wraps.
  - On handshake: latch the operands into `dp_in1`/`dp_in2`, latch the id, set `rr_ptr` = (granted id + 1) mod NREQ, go to LOAD.
  - No valid requests: remain in IDLE, `req_ready` all zero.
- **LOAD:** `dp_load`=1; `dp_special` is sampled this cycle.
  - `dp_special`=1: go to ROUND, skipping ITER.
  - Otherwise: clear the counter `it_cnt` (width $clog2(ITERS+1)) and go to ITER.
- **ITER:** `dp_step`=1 and `it_cnt` increments each cycle. When `it_cnt`==ITERS-1, go to ROUND.
- **ROUND:** capture `dp_out` into `resp_data`, set `resp_valid`, go to RESP.
- **RESP:** hold `resp_valid`, `resp_data` and `resp_id` stable until `resp_ready`. On handshake: clear `resp_valid` and go to IDLE. No request is accepted in the handshake cycle.
- `req_ready` is zero in every non-IDLE state, so the block never holds more than one operation.
- `dp_in1`/`dp_in2` hold their value from accept until the next accept.
- **Reset** (any state, including mid-ITER or in RESP): the next state is IDLE and the in-flight operation is discarded without a response.
  - Reset values: `req_ready` 0, `dp_load` 0, `dp_step` 0, `resp_valid` 0, `resp_data` 0, `resp_id` 0, `dp_in1`/`dp_in2` 0, `busy` 0, `rr_ptr` 0, `it_cnt` 0.
- A `resp_ready` asserted outside RESP is ignored.

## Timing
- Accept handshake in cycle t:
  - LOAD at t+1
  - ITER at t+2 … t+1+ITERS
  - ROUND at t+2+ITERS
  - `resp_valid` first high at t+3+ITERS (t+67 with defaults)
- Special path: LOAD at t+1, ROUND at t+2, `resp_valid` at t+3.
- Minimum request-to-request interval: ITERS+4 cycles (zero response stall).
- `dp_out` must be settled in the ROUND cycle; the datapath is combinational after its last step.
- `dp_load`, `dp_step` and `busy` are registered outputs (decoded from the registered state, no input-to-output paths). `req_ready` is the only combinational output.

## Structure
- **Package `posit_div_pkg`:** state enum `div_state_t` {IDLE, LOAD, ITER, ROUND, RESP} and default parameter constants.
- **Sub-module `rr_arbiter`** (parameter NREQ): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `gnt_id`.
- FSM, iteration counter and response registers live in the top module.

## Test plan
- **Single request:** requester 0, IN1=32'h4000_0000, IN2=32'h4000_0000, model datapath returns 32'h4000_0000. Required: `dp_load` at t+1, exactly 64 `dp_step` cycles, `resp_valid` at t+67, `resp_data`=32'h4000_0000, `resp_id`=0.
- **Special path:** IN2=0, `dp_special`=1. Required: no `dp_step`, `resp_valid` at t+3, `resp_data`=`dp_out` (32'h8000_0000 NaR).
- **Contention:** both `req_valid` held high from reset. Required grant order 0, 1, 0, 1; `resp_id` sequence matches; each accept occurs one cycle after the previous response handshake.
- **Response backpressure:** `resp_ready` low for 10 cycles in RESP. Required: `resp_data`/`resp_id` stable, `req_ready`=0 throughout, IDLE one cycle after `resp_ready` rises.
- **Reset mid-ITER:** `reset` at step 20. Required: next cycle all outputs at reset values, no response issued, and a new request is accepted normally with `rr_ptr`=0.
- **Ignored stimulus:** `req_valid` toggles during ITER and `resp_ready` pulses during LOAD. Required: no effect on sequencing or outputs.

Source files
------------

// File: rtl/posit_div_pkg.sv
// Shared types and defaults for the posit divider scheduler.
// Imported by the scheduler top and its arbiter.
package posit_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    ROUND,
    RESP
  } div_state_t;

  localparam int N_DEF    = 32;
  localparam int ES_DEF   = 2;
  localparam int NREQ_DEF = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps.
// Produces a one-hot grant and the granted index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/posit_div_sched.sv
// Shares one iterative posit divider datapath between NREQ
// requesters: arbitrate, load, iterate, capture, respond.
module posit_div_sched
  import posit_div_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ES    = ES_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int ITERS = 2 * N,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      dp_in1,
  output logic [N-1:0]      dp_in2,
  output logic              dp_load,
  output logic              dp_step,
  input  logic              dp_special,
  input  logic [N-1:0]      dp_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);

  localparam int CW = $clog2(ITERS + 1);

  // ES only configures the datapath; nothing to check beyond sign.
  if (ES < 0) begin : g_es_chk
  end

  div_state_t      state_q, state_d;
  logic [N-1:0]    in1_q, in1_d;
  logic [N-1:0]    in2_q, in2_d;
  logic [N-1:0]    data_q, data_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rv_q, rv_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            arb_en;
  logic            accept;

  // A grant during reset would be discarded, so hide it.
  assign arb_en = (state_q == IDLE) && !reset;
  assign accept = |(req_valid & gnt);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          in1_d   = req_in1[int'(gnt_id)*N +: N];
          in2_d   = req_in2[int'(gnt_id)*N +: N];
          id_d    = gnt_id;
          ptr_d   = IDW'((int'(gnt_id) + 1) % NREQ);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (dp_special) begin
          state_d = ROUND;
        end else begin
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d  = dp_out;
        rv_d    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dp_load = (state_q == LOAD);
    dp_step = (state_q == ITER);
    busy    = (state_q != IDLE);
  end

  assign req_ready  = gnt;
  assign dp_in1     = in1_q;
  assign dp_in2     = in2_q;
  assign resp_valid = rv_q;
  assign resp_data  = data_q;
  assign resp_id    = id_q;

endmodule
